// File: rtl/ipf_feed_pkg.sv
// Shared codes and size lookups for the IPF feeder: ctrl encodings, kernel-size codes, FSM states.
// No logic of its own; the lookups are pure functions of the kernel-size code.
package ipf_feed_pkg;

   localparam logic [1:0] CTRL_END   = 2'd0;
   localparam logic [1:0] CTRL_START = 2'd1;
   localparam logic [1:0] CTRL_HOLD  = 2'd2;

   localparam logic [1:0] WS_3X3     = 2'd0;
   localparam logic [1:0] WS_5X5     = 2'd1;
   localparam logic [1:0] WS_7X7     = 2'd2;
   localparam logic [1:0] WS_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_PRE,
      S_RUN,
      S_TAIL
   } state_t;

   // Lines streamed ahead of START; always even, so stride-2 phase can use bit 0 of the line index.
   function automatic logic [4:0] pre_lines(input logic [1:0] ws);
      case (ws)
         WS_3X3:  return 5'd2;
         WS_5X5:  return 5'd4;
         WS_7X7:  return 5'd6;
         default: return 5'd6;
      endcase
   endfunction

   function automatic logic [4:0] weight_lines(input logic [1:0] ws);
      return (ws == WS_3X3) ? 5'd18 : 5'd25;
   endfunction

   function automatic logic [2:0] num_rounds(input logic [1:0] ws);
      case (ws)
         WS_3X3:  return 3'd1;
         WS_5X5:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/ipf_feed_rdstage.sv
// Two-stage delay of line sideband aligned with 1-cycle-latency SRAM read data; outputs land 2 cycles after the address.
// No backpressure: every issued line emerges; data registers hold their value while the matching valid is low.
module ipf_feed_rdstage
   import ipf_feed_pkg::*;
#(
   parameter int DATA_W = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_vld,
   input  logic              i_sel,
   input  logic [1:0]        i_ctrl,
   input  logic [3:0]        i_wgroup,
   input  logic [2:0]        i_wround,
   input  logic              i_done,
   input  logic [DATA_W-1:0] i_wmem_dat,
   input  logic [DATA_W-1:0] i_imem_dat,
   output logic              o_w_vld,
   output logic              o_i_vld,
   output logic [DATA_W-1:0] o_w_dat,
   output logic [DATA_W-1:0] o_i_dat,
   output logic [1:0]        o_ctrl,
   output logic [3:0]        o_wgroup,
   output logic [2:0]        o_wround,
   output logic              o_done
);

   logic       r_s1_vld;
   logic       r_s1_sel;
   logic [1:0] r_s1_ctrl;
   logic [3:0] r_s1_wgroup;
   logic [2:0] r_s1_wround;
   logic       r_s1_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld    <= 1'b0;
         r_s1_sel    <= 1'b0;
         r_s1_ctrl   <= CTRL_END;
         r_s1_wgroup <= 4'd0;
         r_s1_wround <= 3'd0;
         r_s1_done   <= 1'b0;
         o_w_vld     <= 1'b0;
         o_i_vld     <= 1'b0;
         o_w_dat     <= '0;
         o_i_dat     <= '0;
         o_ctrl      <= CTRL_END;
         o_wgroup    <= 4'd0;
         o_wround    <= 3'd0;
         o_done      <= 1'b0;
      end else begin
         r_s1_vld    <= i_vld;
         r_s1_sel    <= i_sel;
         r_s1_ctrl   <= i_ctrl;
         r_s1_wgroup <= i_wgroup;
         r_s1_wround <= i_wround;
         r_s1_done   <= i_done;
         o_w_vld     <= r_s1_vld && !r_s1_sel;
         o_i_vld     <= r_s1_vld && r_s1_sel;
         o_ctrl      <= r_s1_ctrl;
         o_wgroup    <= r_s1_wgroup;
         o_wround    <= r_s1_wround;
         o_done      <= r_s1_done;
         // SRAM data for the stage-1 line is on the bus now
         if (r_s1_vld && !r_s1_sel) o_w_dat <= i_wmem_dat;
         if (r_s1_vld && r_s1_sel)  o_i_dat <= i_imem_dat;
      end
   end

endmodule

// File: rtl/ipf_feeder.sv
// IPF input-stream sequencer: per command, weight lines then grouped/rounded passes of input lines, then a HOLD tail.
// Stream trails read addresses by 2 cycles; no downstream backpressure, cmd_ready is high only while idle.
module ipf_feeder
   import ipf_feed_pkg::*;
#(
   parameter int DATA_W   = 512,
   parameter int ADDR_W   = 16,
   parameter int TAIL_CYC = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_wsize,
   input  logic              cmd_stride,
   input  logic [3:0]        cmd_ngroups,
   input  logic [4:0]        cmd_ilines,
   input  logic [ADDR_W-1:0] cmd_w_base,
   input  logic [ADDR_W-1:0] cmd_i_base,
   output logic              cmd_err,
   output logic              done,
   output logic              w_rd_en,
   output logic [ADDR_W-1:0] w_rd_addr,
   input  logic [DATA_W-1:0] w_rd_data,
   output logic              i_rd_en,
   output logic [ADDR_W-1:0] i_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              w_valid,
   output logic [DATA_W-1:0] w_data,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_data,
   output logic [1:0]        ctrl,
   output logic [1:0]        Wsize,
   output logic              stride,
   output logic [3:0]        wgroup,
   output logic [2:0]        wround
);

   localparam int                TAIL_W    = $clog2(TAIL_CYC + 3);
   localparam logic [TAIL_W-1:0] TAIL_END  = TAIL_W'(TAIL_CYC);
   localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYC + 2);

   state_t            r_state;
   logic [4:0]        r_line;
   logic [2:0]        r_round;
   logic [3:0]        r_group;
   logic [TAIL_W-1:0] r_tail;
   logic [1:0]        r_wsize;
   logic              r_stride;
   logic [3:0]        r_ngroups;
   logic [4:0]        r_ilines;
   logic [ADDR_W-1:0] r_w_base;
   logic [ADDR_W-1:0] r_i_base;
   logic              r_cmd_err;

   logic       w_cmd_bad;
   logic [4:0] w_pre;
   logic [4:0] w_run_idx;
   logic       w_last_line;
   logic       w_last_round;
   logic       w_last_group;
   logic       w_p_vld;
   logic       w_p_sel;
   logic [1:0] w_p_ctrl;
   logic [3:0] w_p_wgroup;
   logic [2:0] w_p_wround;
   logic       w_p_done;

   assign w_cmd_bad    = (cmd_wsize == WS_ILLEGAL) || (cmd_ilines <= pre_lines(cmd_wsize));
   assign w_pre        = pre_lines(r_wsize);
   assign w_run_idx    = r_line - w_pre;
   assign w_last_line  = (r_line == r_ilines - 5'd1);
   assign w_last_round = (r_round == num_rounds(r_wsize) - 3'd1);
   assign w_last_group = r_stride || (r_group == r_ngroups);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_line    <= 5'd0;
         r_round   <= 3'd0;
         r_group   <= 4'd0;
         r_tail    <= '0;
         r_wsize   <= 2'd0;
         r_stride  <= 1'b0;
         r_ngroups <= 4'd0;
         r_ilines  <= 5'd0;
         r_w_base  <= '0;
         r_i_base  <= '0;
         r_cmd_err <= 1'b0;
      end else begin
         r_cmd_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && w_cmd_bad) begin
                  r_cmd_err <= 1'b1;
               end else if (cmd_valid) begin
                  r_wsize   <= cmd_wsize;
                  r_stride  <= cmd_stride;
                  r_ngroups <= cmd_ngroups;
                  r_ilines  <= cmd_ilines;
                  r_w_base  <= cmd_w_base;
                  r_i_base  <= cmd_i_base;
                  r_line    <= 5'd0;
                  r_round   <= 3'd0;
                  r_group   <= 4'd0;
                  r_state   <= S_WLOAD;
               end
            end
            S_WLOAD: begin
               if (r_line == weight_lines(r_wsize) - 5'd1) begin
                  r_line  <= 5'd0;
                  r_state <= S_PRE;
               end else begin
                  r_line <= r_line + 5'd1;
               end
            end
            S_PRE, S_RUN: begin
               if (w_last_line) begin
                  r_line <= 5'd0;
                  if (!w_last_round) begin
                     r_round <= r_round + 3'd1;
                     r_state <= S_PRE;
                  end else if (!w_last_group) begin
                     r_round <= 3'd0;
                     r_group <= r_group + 4'd1;
                     r_state <= S_PRE;
                  end else begin
                     r_round <= 3'd0;
                     r_state <= S_TAIL;
                  end
               end else begin
                  r_line <= r_line + 5'd1;
                  if (r_line == w_pre - 5'd1) r_state <= S_RUN;
               end
            end
            S_TAIL: begin
               // Two extra cycles let END/done drain the pipe before cmd_ready rises
               if (r_tail == TAIL_LAST) begin
                  r_tail  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_tail <= r_tail + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_p_vld    = 1'b0;
      w_p_sel    = 1'b0;
      w_p_ctrl   = CTRL_HOLD;
      w_p_wgroup = 4'd0;
      w_p_wround = 3'd0;
      w_p_done   = 1'b0;
      case (r_state)
         S_IDLE:  w_p_ctrl = CTRL_END;
         S_WLOAD: w_p_vld  = 1'b1;
         S_PRE: begin
            w_p_vld    = 1'b1;
            w_p_sel    = 1'b1;
            w_p_wround = r_round;
            w_p_wgroup = r_stride ? 4'd0 : r_group;
         end
         S_RUN: begin
            w_p_vld    = 1'b1;
            w_p_sel    = 1'b1;
            w_p_ctrl   = CTRL_START;
            w_p_wround = r_round;
            w_p_wgroup = r_stride ? {3'd0, w_run_idx[0]} : r_group;
         end
         S_TAIL: begin
            if (r_tail >= TAIL_END) w_p_ctrl = CTRL_END;
            w_p_done = (r_tail == TAIL_END);
         end
         default: ;
      endcase
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign cmd_err   = r_cmd_err;
   assign Wsize     = r_wsize;
   assign stride    = r_stride;
   assign w_rd_en   = (r_state == S_WLOAD);
   assign w_rd_addr = r_w_base + ADDR_W'(r_line);
   assign i_rd_en   = (r_state == S_PRE) || (r_state == S_RUN);
   assign i_rd_addr = r_i_base + ADDR_W'(r_line);

   ipf_feed_rdstage #(.DATA_W(DATA_W)) u_rdstage (
      .clk        (clk),
      .rst        (rst),
      .i_vld      (w_p_vld),
      .i_sel      (w_p_sel),
      .i_ctrl     (w_p_ctrl),
      .i_wgroup   (w_p_wgroup),
      .i_wround   (w_p_wround),
      .i_done     (w_p_done),
      .i_wmem_dat (w_rd_data),
      .i_imem_dat (i_rd_data),
      .o_w_vld    (w_valid),
      .o_i_vld    (i_valid),
      .o_w_dat    (w_data),
      .o_i_dat    (i_data),
      .o_ctrl     (ctrl),
      .o_wgroup   (wgroup),
      .o_wround   (wround),
      .o_done     (done)
   );

endmodule

// File: tb/tb_ipf_feeder.sv
// Randomized bench for ipf_feeder: expected per-cycle stream built from kernel-size rules and compared cycle by cycle.
module tb_ipf_feeder;

   localparam int DW = 512;
   localparam int AW = 16;
   localparam int TC = 10;
   localparam logic [1:0] C_END = 2'd0, C_START = 2'd1, C_HOLD = 2'd2;

   logic          clk, rst;
   logic          cmd_valid, cmd_ready, cmd_stride, cmd_err, done;
   logic [1:0]    cmd_wsize;
   logic [3:0]    cmd_ngroups;
   logic [4:0]    cmd_ilines;
   logic [AW-1:0] cmd_w_base, cmd_i_base, w_rd_addr, i_rd_addr;
   logic          w_rd_en, i_rd_en, w_valid, i_valid, stride;
   logic [DW-1:0] w_rd_data, i_rd_data, w_data, i_data;
   logic [1:0]    ctrl, Wsize;
   logic [3:0]    wgroup;
   logic [2:0]    wround;

   typedef struct packed {
      logic          wv;
      logic          iv;
      logic [1:0]    ctrl;
      logic          done;
      logic [3:0]    wg;
      logic [2:0]    wr;
      logic [DW-1:0] wd;
      logic [DW-1:0] id;
   } exp_t;

   int            n_vec, n_err;
   logic [31:0]   wseed, iseed;
   logic [DW-1:0] m_last_w, m_last_i;

   ipf_feeder #(.DATA_W(DW), .ADDR_W(AW), .TAIL_CYC(TC)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wsize(cmd_wsize), .cmd_stride(cmd_stride), .cmd_ngroups(cmd_ngroups),
      .cmd_ilines(cmd_ilines), .cmd_w_base(cmd_w_base), .cmd_i_base(cmd_i_base),
      .cmd_err(cmd_err), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
      .w_rd_data(w_rd_data), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
      .w_valid(w_valid), .w_data(w_data), .i_valid(i_valid), .i_data(i_data),
      .ctrl(ctrl), .Wsize(Wsize), .stride(stride), .wgroup(wgroup), .wround(wround)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic [31:0] seed);
      logic [DW-1:0] r;
      logic [31:0]   x;
      x = {a, a ^ 16'h5A3C} ^ seed;
      for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = x ^ (32'h9E3779B9 * k);
      return r;
   endfunction

   // Line SRAMs with one-cycle read latency; bus carries noise when not read.
   always @(posedge clk) begin
      w_rd_data <= w_rd_en ? mem_word(w_rd_addr, wseed) : {(DW / 32){$urandom}};
      i_rd_data <= i_rd_en ? mem_word(i_rd_addr, iseed) : {(DW / 32){$urandom}};
   end

   function automatic int pre_of(input int ws);
      return (ws == 0) ? 2 : (ws == 1) ? 4 : 6;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({cmd_ready, ctrl, w_valid, i_valid, done, cmd_err, w_rd_en, i_rd_en} !== {1'b1, C_END, 6'b0}) begin
         n_err++;
         $display("FAIL reset_ctl: got rdy=%b ctrl=%0d wv=%b iv=%b done=%b err=%b wre=%b ire=%b want rdy=1 ctrl=0 rest 0",
                  cmd_ready, ctrl, w_valid, i_valid, done, cmd_err, w_rd_en, i_rd_en);
      end
      n_vec++;
      if ({Wsize, stride, wgroup, wround} !== 10'd0 || w_data !== '0 || i_data !== '0) begin
         n_err++;
         $display("FAIL reset_side: got Wsize=%0d stride=%b wg=%0d wr=%0d wdat_zero=%b idat_zero=%b want all 0",
                  Wsize, stride, wgroup, wround, w_data == '0, i_data == '0);
      end
      rst = 1'b0;
      m_last_w = '0;
      m_last_i = '0;
      @(posedge clk);
      #1;
      n_vec++;
      if (cmd_ready !== 1'b1 || ctrl !== C_END) begin
         n_err++;
         $display("FAIL reset_release: got rdy=%b ctrl=%0d want rdy=1 ctrl=0", cmd_ready, ctrl);
      end
   endtask

   // One command end to end; abort_idx >= 0 asserts rst while that stream entry is on the outputs.
   task automatic test_command(input int ws, input int st, input int ng, input int il,
                               input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                               input bit hold_v, input int abort_idx);
      exp_t q[$];
      exp_t e;
      int   pre, wl, nr, ngr, len, wrd, ird, errc;
      pre = pre_of(ws);
      wl  = (ws == 0) ? 18 : 25;
      nr  = (ws == 0) ? 1 : (ws == 1) ? 2 : 4;
      ngr = (st != 0) ? 1 : ng + 1;
      e = '0;
      for (int k = 0; k < wl; k++) begin
         e = '0;
         e.wv = 1'b1; e.ctrl = C_HOLD;
         e.wd = mem_word(AW'(wb + k), wseed); e.id = m_last_i;
         m_last_w = e.wd;
         q.push_back(e);
      end
      for (int g = 0; g < ngr; g++)
         for (int r = 0; r < nr; r++)
            for (int j = 0; j < il; j++) begin
               e = '0;
               e.iv = 1'b1;
               e.ctrl = (j < pre) ? C_HOLD : C_START;
               e.wr = 3'(r);
               if (st != 0) e.wg = (j < pre) ? 4'd0 : 4'((j - pre) % 2);
               else         e.wg = 4'(g);
               e.wd = m_last_w; e.id = mem_word(AW'(ib + j), iseed);
               m_last_i = e.id;
               q.push_back(e);
            end
      for (int t = 0; t <= TC; t++) begin
         e = '0;
         e.ctrl = (t < TC) ? C_HOLD : C_END;
         e.done = (t == TC);
         e.wd = m_last_w; e.id = m_last_i;
         q.push_back(e);
      end
      len = q.size();

      cmd_wsize = 2'(ws); cmd_stride = st[0]; cmd_ngroups = 4'(ng); cmd_ilines = 5'(il);
      cmd_w_base = wb; cmd_i_base = ib; cmd_valid = 1'b1;
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
      end
      @(posedge clk);
      #1;
      if (!hold_v) cmd_valid = 1'b0;
      wrd = 0; ird = 0; errc = 0;
      for (int off = 0; off <= len + 2; off++) begin
         wrd += int'(w_rd_en);
         ird += int'(i_rd_en);
         errc += int'(cmd_err);
         if (off < len + 2) begin
            n_vec++;
            if (cmd_ready !== 1'b0) begin
               n_err++;
               $display("FAIL busy_ready: off=%0d got %b want 0", off, cmd_ready);
            end
         end
         if (off == 2) begin
            n_vec++;
            if (Wsize !== 2'(ws) || stride !== st[0]) begin
               n_err++;
               $display("FAIL cmd_copy: got Wsize=%0d stride=%b want %0d %0d", Wsize, stride, ws, st);
            end
         end
         if (off >= 2 && off < len + 2) begin
            e = q[off-2];
            n_vec++;
            if ({w_valid, i_valid, ctrl, done} !== {e.wv, e.iv, e.ctrl, e.done}) begin
               n_err++;
               $display("FAIL stream_ctl: idx=%0d got wv=%b iv=%b ctrl=%0d done=%b want wv=%b iv=%b ctrl=%0d done=%b",
                        off - 2, w_valid, i_valid, ctrl, done, e.wv, e.iv, e.ctrl, e.done);
            end
            n_vec++;
            if (w_data !== e.wd) begin
               n_err++;
               $display("FAIL w_data: idx=%0d got %h want %h", off - 2, w_data[63:0], e.wd[63:0]);
            end
            n_vec++;
            if (i_data !== e.id) begin
               n_err++;
               $display("FAIL i_data: idx=%0d got %h want %h", off - 2, i_data[63:0], e.id[63:0]);
            end
            if (e.iv) begin
               n_vec++;
               if (wgroup !== e.wg || wround !== e.wr) begin
                  n_err++;
                  $display("FAIL grp_round: idx=%0d got wg=%0d wr=%0d want wg=%0d wr=%0d",
                           off - 2, wgroup, wround, e.wg, e.wr);
               end
            end
            if (off - 2 == abort_idx) begin
               rst = 1'b1;
               cmd_valid = 1'b0;
               @(posedge clk);
               #1;
               return;
            end
         end
         if (off == len + 2) begin
            n_vec++;
            if (cmd_ready !== 1'b1 || ctrl !== C_END || done !== 1'b0) begin
               n_err++;
               $display("FAIL after_done: got rdy=%b ctrl=%0d done=%b want 1 0 0", cmd_ready, ctrl, done);
            end
            cmd_valid = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      n_vec++;
      if (wrd != wl || ird != ngr * nr * il || errc != 0) begin
         n_err++;
         $display("FAIL read_count: got w=%0d i=%0d err=%0d want w=%0d i=%0d err=0",
                  wrd, ird, errc, wl, ngr * nr * il);
      end
   endtask

   task automatic test_illegal(input int ws, input int il);
      cmd_wsize = 2'(ws); cmd_stride = 1'($urandom_range(0, 1)); cmd_ngroups = 4'($urandom_range(0, 15));
      cmd_ilines = 5'(il); cmd_w_base = AW'($urandom); cmd_i_base = AW'($urandom);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      n_vec++;
      if ({cmd_err, cmd_ready, w_rd_en, i_rd_en} !== 4'b1100) begin
         n_err++;
         $display("FAIL illegal_pulse: ws=%0d il=%0d got err=%b rdy=%b wre=%b ire=%b want 1 1 0 0",
                  ws, il, cmd_err, cmd_ready, w_rd_en, i_rd_en);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({cmd_err, cmd_ready, w_rd_en, i_rd_en, w_valid, i_valid} !== 6'b010000) begin
         n_err++;
         $display("FAIL illegal_after: ws=%0d got err=%b rdy=%b wre=%b ire=%b wv=%b iv=%b want 0 1 0 0 0 0",
                  ws, cmd_err, cmd_ready, w_rd_en, i_rd_en, w_valid, i_valid);
      end
   endtask

   task automatic test_busy_ignore();
      test_command(0, 0, 0, 5, AW'($urandom), AW'($urandom), 1'b1, -1);
      test_command(1, 1, 3, 9, AW'($urandom), AW'($urandom), 1'b0, -1);
   endtask

   task automatic test_reset_midrun();
      test_command(0, 0, 1, 16, 16'd0, 16'd0, 1'b0, 18 + 16 + 5);
      n_vec++;
      if ({ctrl, i_valid, w_valid, cmd_ready, done} !== {C_END, 4'b0010} || i_data !== '0) begin
         n_err++;
         $display("FAIL midrun_reset: got ctrl=%0d iv=%b wv=%b rdy=%b done=%b idat_zero=%b want 0 0 0 1 0 1",
                  ctrl, i_valid, w_valid, cmd_ready, done, i_data == '0);
      end
      rst = 1'b0;
      m_last_w = '0;
      m_last_i = '0;
      @(posedge clk);
      #1;
      test_command(0, 0, 1, 16, 16'd0, 16'd0, 1'b0, -1);
   endtask

   task automatic test_random_cmds(input int n);
      int ws, st, ng, il;
      for (int i = 0; i < n; i++) begin
         ws = $urandom_range(0, 2);
         st = $urandom_range(0, 1);
         ng = $urandom_range(0, 3);
         il = $urandom_range(pre_of(ws) + 1, 16);
         test_command(ws, st, ng, il, AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), -1);
         if ($urandom_range(0, 1) == 1) test_illegal(3, $urandom_range(0, 31));
         else test_illegal(ws, $urandom_range(0, pre_of(ws)));
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      wseed = $urandom; iseed = $urandom;
      rst = 1'b1; cmd_valid = 1'b0; cmd_wsize = 2'd0; cmd_stride = 1'b0; cmd_ngroups = 4'd0;
      cmd_ilines = 5'd0; cmd_w_base = '0; cmd_i_base = '0;
      m_last_w = '0; m_last_i = '0;
      test_reset();
      test_command(0, 0, 1, 16, 16'd0, 16'd0, 1'b0, -1);
      test_command(1, 0, 0, 8, AW'($urandom), AW'($urandom), 1'b0, -1);
      test_command(2, 1, int'($urandom_range(0, 15)), 8, AW'($urandom), AW'($urandom), 1'b0, -1);
      test_illegal(3, 8);
      test_illegal(0, 2);
      test_illegal(2, 6);
      test_command(0, 0, 0, 3, 16'hFFF8, 16'hFFFE, 1'b0, -1);
      test_command(2, 1, 0, 7, 16'hFFF0, 16'hFFFB, 1'b0, -1);
      test_busy_ignore();
      test_reset_midrun();
      test_random_cmds(6);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
